// File: rtl/uart_parity_engine.sv
// uart_parity_engine: serial UART RX data/parity checker; UART_PARITY_ERR_COUNT_EN builds the saturating error counter
module uart_parity_engine #(
  parameter int MAX_DATA_WIDTH = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   start_i,
  input  logic [$clog2(MAX_DATA_WIDTH+1)-1:0]    data_bits_i,
  input  logic [2:0]                             parity_mode_i,
  input  logic                                   bit_valid_i,
  input  logic                                   bit_i,
  input  logic                                   err_clear_i,
  output logic                                   busy_o,
  output logic                                   frame_valid_o,
  output logic [MAX_DATA_WIDTH-1:0]              data_o,
  output logic                                   parity_error_o,
  output logic [ERR_CNT_WIDTH-1:0]               err_count_o
);
  localparam int DW = $clog2(MAX_DATA_WIDTH + 1);
  localparam int IW = MAX_DATA_WIDTH > 1 ? $clog2(MAX_DATA_WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, DONE} state_t;
  state_t state;
  logic [DW-1:0] nbits, nbits_in, cnt;
  logic [2:0] mode;
  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic run_xor, rx_par, has_par, exp_par, perr;
  always_comb begin
    nbits_in = (data_bits_i == '0 || int'(data_bits_i) > MAX_DATA_WIDTH) ? DW'(MAX_DATA_WIDTH) : data_bits_i;
    has_par = (mode != 3'd0) && (mode < 3'd5);
    exp_par = mode == 3'd1 ? run_xor : mode == 3'd2 ? ~run_xor : mode == 3'd3;
    perr = has_par && (rx_par != exp_par);
  end
  assign busy_o = state != IDLE;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      nbits <= '0;
      cnt <= '0;
      mode <= '0;
      shreg <= '0;
      run_xor <= 1'b0;
      rx_par <= 1'b0;
      frame_valid_o <= 1'b0;
      data_o <= '0;
      parity_error_o <= 1'b0;
    end else begin
      frame_valid_o <= 1'b0;
      if (state == DONE) begin
        frame_valid_o <= 1'b1;
        data_o <= shreg;
        parity_error_o <= perr;
      end
      // start wins in every state: aborts DATA/PARITY, follows DONE straight into DATA
      if (start_i) begin
        state <= DATA;
        nbits <= nbits_in;
        mode <= parity_mode_i;
        cnt <= '0;
        shreg <= '0;
        run_xor <= 1'b0;
        rx_par <= 1'b0;
      end else begin
        case (state)
          DATA: if (bit_valid_i) begin
            shreg[cnt[IW-1:0]] <= bit_i;
            run_xor <= run_xor ^ bit_i;
            cnt <= cnt + DW'(1);
            if (cnt == nbits - DW'(1)) state <= has_par ? PARITY : DONE;
          end
          PARITY: if (bit_valid_i) begin
            rx_par <= bit_i;
            state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
`ifdef UART_PARITY_ERR_COUNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || err_clear_i) err_cnt <= '0;
    else if (state == DONE && perr && !(&err_cnt)) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
  end
  assign err_count_o = err_cnt;
`else
  logic unused_err_clear;
  assign unused_err_clear = err_clear_i;
  assign err_count_o = '0;
`endif
endmodule

// File: tb/tb_uart_parity_engine.sv
// tb_uart_parity_engine: scoreboard bench for uart_parity_engine (narrow counter to reach saturation)
module tb_uart_parity_engine;
  localparam int MW = 8, CW = 2;
  logic clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, bit_valid_i = 1'b0, bit_i = 1'b0, err_clear_i = 1'b0;
  logic [3:0] data_bits_i = '0;
  logic [2:0] parity_mode_i = '0;
  logic busy_o, frame_valid_o, parity_error_o;
  logic [MW-1:0] data_o;
  logic [CW-1:0] err_count_o;
  int total = 0, bad = 0, exp_cnt = 0;
  logic seen;
  typedef struct packed { logic [MW-1:0] d; logic pe; logic [CW-1:0] c; } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  uart_parity_engine #(.MAX_DATA_WIDTH(MW), .ERR_CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .data_bits_i(data_bits_i),
    .parity_mode_i(parity_mode_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
    .err_clear_i(err_clear_i), .busy_o(busy_o), .frame_valid_o(frame_valid_o),
    .data_o(data_o), .parity_error_o(parity_error_o), .err_count_o(err_count_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_frame(input string tag, input logic [3:0] nb, input logic [2:0] md,
                           input logic [MW-1:0] d, input logic p, input logic clr);
    int n, k;
    logic hp, x, ep, pe;
    logic [MW-1:0] m;
    exp_t e;
    n = (nb == 4'd0 || int'(nb) > MW) ? MW : int'(nb);
    m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    hp = md >= 3'd1 && md <= 3'd4;
    x = ^(d & m);
    ep = md == 3'd1 ? x : md == 3'd2 ? ~x : md == 3'd3;
    pe = hp && (p != ep);
`ifdef UART_PARITY_ERR_COUNT_EN
    exp_cnt = clr ? 0 : (pe && exp_cnt < (1 << CW) - 1) ? exp_cnt + 1 : exp_cnt;
`endif
    e.d = d & m;
    e.pe = pe;
    e.c = CW'(exp_cnt);
    q.push_back(e);
    start_i = 1'b1; data_bits_i = nb; parity_mode_i = md;
    @(negedge clk);
    start_i = 1'b0; data_bits_i = 4'd3; parity_mode_i = ~md;
    chk({tag, "_busy"}, busy_o, 1);
    for (int i = 0; i < n; i++) begin
      bit_valid_i = 1'b1; bit_i = d[i];
      @(negedge clk);
    end
    if (hp) begin
      bit_valid_i = 1'b1; bit_i = p;
      @(negedge clk);
    end
    bit_valid_i = 1'b0; err_clear_i = clr;
    for (k = 0; k < 4 && !frame_valid_o; k++) begin
      @(negedge clk);
      err_clear_i = 1'b0;
    end
    err_clear_i = 1'b0;
    chk({tag, "_lat"}, k, 1);
    e = q.pop_front();
    chk({tag, "_data"}, data_o, e.d);
    chk({tag, "_perr"}, parity_error_o, e.pe);
    chk({tag, "_cnt"}, err_count_o, e.c);
    chk({tag, "_idle"}, busy_o, 0);
    @(negedge clk);
    chk({tag, "_pulse"}, frame_valid_o, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_fv", frame_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_perr", parity_error_o, 0);
    chk("rst_cnt", err_count_o, 0);
    rst_ni = 1'b1;
    bit_valid_i = 1'b1; bit_i = 1'b1;
    repeat (3) @(negedge clk);
    bit_valid_i = 1'b0;
    chk("idle_ignore_busy", busy_o, 0);
    chk("idle_ignore_fv", frame_valid_o, 0);
    run_frame("even_a5", 4'd8, 3'd1, 8'hA5, 1'b0, 1'b0);
    run_frame("odd_35_err", 4'd7, 3'd2, 8'h35, 1'b0, 1'b0);
    run_frame("odd_35_ok", 4'd7, 3'd2, 8'h35, 1'b1, 1'b0);
    run_frame("none_5", 4'd5, 3'd0, 8'hFF, 1'b0, 1'b0);
    run_frame("zero_bits_m5", 4'd0, 3'd5, 8'hC3, 1'b0, 1'b0);
    run_frame("mark_6", 4'd6, 3'd3, 8'h00, 1'b0, 1'b0);
    run_frame("space_6", 4'd6, 3'd4, 8'h00, 1'b0, 1'b0);
    start_i = 1'b1; data_bits_i = 4'd8; parity_mode_i = 3'd1;
    @(negedge clk);
    start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid_i = 1'b1; bit_i = 1'b1;
      @(negedge clk);
      seen = seen | frame_valid_o;
    end
    bit_valid_i = 1'b0;
    run_frame("abort_3c", 4'd8, 3'd1, 8'h3C, 1'b0, 1'b0);
    chk("abort_no_fv", seen, 0);
    run_frame("clamp12_81", 4'd12, 3'd1, 8'h81, 1'b1, 1'b0);
    run_frame("sat_hold", 4'd6, 3'd3, 8'h00, 1'b0, 1'b0);
    run_frame("clr_with_err", 4'd6, 3'd3, 8'h00, 1'b0, 1'b1);
    run_frame("after_clr", 4'd8, 3'd2, 8'h00, 1'b0, 1'b0);
    start_i = 1'b1; data_bits_i = 4'd8; parity_mode_i = 3'd1;
    @(negedge clk);
    start_i = 1'b0;
    bit_valid_i = 1'b1; bit_i = 1'b1;
    repeat (4) @(negedge clk);
    bit_valid_i = 1'b0;
    rst_ni = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | frame_valid_o;
    end
    chk("midrst_busy", busy_o, 0);
    chk("midrst_no_fv", seen, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_cnt", err_count_o, 0);
    run_frame("post_rst", 4'd4, 3'd1, 8'h0B, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
